// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and data memory.
// master: the MEM stage. It drives req/we/addr/wdata/wstrb and receives rdata/ack.
// slave : data memory. It drives rdata/ack.
// dm_req is held until dm_ack. dm_ack is a single-cycle pulse. dm_rdata is valid with dm_ack.
interface mem_access_stage_if #(parameter int ADDR_W = 16);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [3:0]        dm_wstrb;
  logic [31:0]       dm_rdata;
  logic              dm_ack;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
                  input  dm_rdata, dm_ack);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
                  output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller that sits after the EX/MEM register.
//
// Non-memory instructions retire one cycle later with alu_out passed through.
// Loads and stores run one req/ack transaction on the dm bus. The stage stalls
// upstream while that transaction is outstanding.
// Misaligned accesses, undefined funct3 and read+write together retire with
// wb_err=1 and do not raise a request.
//
// Optional macro MEM_TIMEOUT_EN: abort a WAIT that lasts TIMEOUT_CYC cycles
// without an ack. The instruction then retires with wb_err=1.
//
// Ports:
//   clk, rst                   clock; synchronous active-low reset
//   in_valid, pc_in, alu_out_in, rs2_data_in,
//   mem_read, mem_write, funct3        EX/MEM slot contents
//   stall_o                    combinational hold for upstream stages
//   dm                         data-memory bus (mem_access_stage_if.master)
//   wb_valid/wb_pc/wb_data/wb_err      registered result for MEM/WB
module mem_access_stage #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [15:0]         pc_in,
  input  logic [31:0]         alu_out_in,
  input  logic [31:0]         rs2_data_in,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          funct3,
  output logic                stall_o,
  mem_access_stage_if.master  dm,
  output logic                wb_valid,
  output logic [15:0]         wb_pc,
  output logic [31:0]         wb_data,
  output logic                wb_err
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic [15:0]       pc_q, pc_d;
  logic              wb_valid_q, wb_valid_d, wb_err_q, wb_err_d;
  logic [15:0]       wb_pc_q, wb_pc_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              expired;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Expiry is flagged in the TIMEOUT_CYC-th WAIT cycle. The counter is 0 in the first one.
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  // With the timeout compiled out, WAIT never expires.
  assign expired = (TIMEOUT_CYC < 0);
`endif

  // Decode the instruction in the EX/MEM slot.
  logic [1:0]  lo;
  logic        mem_op, f3_ok, misal, bad;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;

  assign lo     = alu_out_in[1:0];
  assign mem_op = mem_read | mem_write;

  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = mem_read;   // LBU/LHU have no store counterpart
      default:                f3_ok = 1'b0;
    endcase
    misal = ((funct3[1:0] == 2'b01) && lo[0]) || ((funct3[1:0] == 2'b10) && (lo != 2'b00));
    bad   = (mem_read & mem_write) | ~f3_ok | misal;
  end

  // Store lanes: replicate the data and enable only the addressed bytes.
  always_comb begin
    case (funct3[1:0])
      2'b00:   begin st_wstrb = 4'b0001 << lo;                   st_wdata = {4{rs2_data_in[7:0]}};  end
      2'b01:   begin st_wstrb = lo[1] ? 4'b1100 : 4'b0011;       st_wdata = {2{rs2_data_in[15:0]}}; end
      default: begin st_wstrb = 4'b1111;                         st_wdata = rs2_data_in;            end
    endcase
  end

  // Load extraction. Halves are aligned here, so the shifted low 16 bits hold the correct half.
  logic [31:0] sh, ld_data;
  always_comb begin
    sh = dm.dm_rdata >> {lo_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_data = {24'd0, sh[7:0]};
      3'b101:  ld_data = {16'd0, sh[15:0]};
      default: ld_data = dm.dm_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    f3_d       = f3_q;
    lo_d       = lo_q;
    pc_d       = pc_q;
    wb_valid_d = 1'b0;
    wb_pc_d    = wb_pc_q;
    wb_data_d  = wb_data_q;
    wb_err_d   = wb_err_q;
    stall_o    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = pc_in;
            wb_data_d  = alu_out_in;
            wb_err_d   = 1'b0;
          end else if (bad) begin
            wb_valid_d = 1'b1;
            wb_pc_d    = pc_in;
            wb_data_d  = 32'd0;
            wb_err_d   = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = S_WAIT;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {alu_out_in[ADDR_W-1:2], 2'b00};
            wdata_d = mem_write ? st_wdata : 32'd0;
            wstrb_d = mem_write ? st_wstrb : 4'd0;
            f3_d    = funct3;
            lo_d    = lo;
            pc_d    = pc_in;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      default: begin
        stall_o = ~dm.dm_ack & ~expired;
        if (dm.dm_ack) begin
          // An ack in the expiry cycle still completes the access normally.
          state_d    = S_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_pc_d    = pc_q;
          wb_data_d  = we_q ? 32'd0 : ld_data;
          wb_err_d   = 1'b0;
        end else if (expired) begin
          state_d    = S_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_pc_d    = pc_q;
          wb_data_d  = 32'd0;
          wb_err_d   = 1'b1;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      pc_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      f3_q       <= f3_d;
      lo_q       <= lo_d;
      pc_q       <= pc_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign dm.dm_wstrb = wstrb_q;
  assign wb_valid    = wb_valid_q;
  assign wb_pc       = wb_pc_q;
  assign wb_data     = wb_data_q;
  assign wb_err      = wb_err_q;
endmodule
